// File: rtl/vga_pixel_out.sv
// vga_pixel_out: VGA raster generator (default 640x480@60) consuming RGB332
// bytes from the read side of the pixel FIFO and driving registered sync,
// DE and RGB565 outputs.
// Optional feature: define VGA_UNDERFLOW_STAT_EN to add the UNDERFLOW_FLAG
// and UNDERFLOW_CNT status ports.
module vga_pixel_out #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter logic        SYNC_POL = 1'b0
) (
   input  logic        Sys_clk,
   input  logic        Rst,
   input  logic        VGA_START,
   input  logic        VGA_FIFO_EMPTY,
   output logic        VGA_FIFO_RD_EN,
   input  logic [7:0]  VGA_FIFO_RD_DATA,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic        VGA_DE,
   output logic [4:0]  VGA_R,
   output logic [5:0]  VGA_G,
   output logic [4:0]  VGA_B,
   output logic        FRAME_START
`ifdef VGA_UNDERFLOW_STAT_EN
   ,
   output logic        UNDERFLOW_FLAG,
   output logic [15:0] UNDERFLOW_CNT
`endif
);

   localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [9:0] r_h_cnt;
   logic [9:0] r_v_cnt;

   logic       w_run;
   logic       w_active;
   logic       w_hsync;
   logic       w_vsync;
   logic       w_underflow;

   // first delay stage: region flags for the slot whose data is in flight
   logic       r_p1_de;
   logic       r_p1_hs;
   logic       r_p1_vs;
   logic       r_p1_blk;
   logic       r_p1_fs;

   assign w_run    = (r_state == ST_RUN);
   assign w_active = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
   assign w_hsync  = (r_h_cnt >= HS_BEG) && (r_h_cnt <= HS_END);
   assign w_vsync  = (r_v_cnt >= VS_BEG) && (r_v_cnt <= VS_END);

   // state register
   always_ff @(posedge Sys_clk) begin
      if (Rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // next state, FIFO pop strobe and underflow detect
   always_comb begin
      w_state_nxt    = r_state;
      VGA_FIFO_RD_EN = 1'b0;
      w_underflow    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (VGA_START) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            VGA_FIFO_RD_EN = w_active & ~VGA_FIFO_EMPTY;
            w_underflow    = w_active & VGA_FIFO_EMPTY;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // raster counters; held at (0,0) while idle
   always_ff @(posedge Sys_clk) begin
      if (Rst || !w_run) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (r_h_cnt == H_LAST) begin
         r_h_cnt <= '0;
         r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 10'd1;
      end else begin
         r_h_cnt <= r_h_cnt + 10'd1;
      end
   end

   // stage 1: capture region flags while the FIFO fetches the pixel
   always_ff @(posedge Sys_clk) begin
      if (Rst) begin
         r_p1_de  <= 1'b0;
         r_p1_hs  <= 1'b0;
         r_p1_vs  <= 1'b0;
         r_p1_blk <= 1'b0;
         r_p1_fs  <= 1'b0;
      end else begin
         r_p1_de  <= w_run & w_active;
         r_p1_hs  <= w_run & w_hsync;
         r_p1_vs  <= w_run & w_vsync;
         r_p1_blk <= w_underflow;
         r_p1_fs  <= w_run & (r_h_cnt == '0) & (r_v_cnt == '0);
      end
   end

   // stage 2: registered outputs aligned with the returned FIFO byte
   always_ff @(posedge Sys_clk) begin
      if (Rst) begin
         VGA_HS      <= ~SYNC_POL;
         VGA_VS      <= ~SYNC_POL;
         VGA_DE      <= 1'b0;
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
         FRAME_START <= 1'b0;
      end else begin
         VGA_HS      <= r_p1_hs ? SYNC_POL : ~SYNC_POL;
         VGA_VS      <= r_p1_vs ? SYNC_POL : ~SYNC_POL;
         VGA_DE      <= r_p1_de;
         FRAME_START <= r_p1_fs;
         if (r_p1_de && !r_p1_blk) begin
            VGA_R <= {VGA_FIFO_RD_DATA[7:5], VGA_FIFO_RD_DATA[7:6]};
            VGA_G <= {VGA_FIFO_RD_DATA[4:2], VGA_FIFO_RD_DATA[4:2]};
            VGA_B <= {VGA_FIFO_RD_DATA[1:0], VGA_FIFO_RD_DATA[1:0], VGA_FIFO_RD_DATA[1]};
         end else begin
            VGA_R <= '0;
            VGA_G <= '0;
            VGA_B <= '0;
         end
      end
   end

`ifdef VGA_UNDERFLOW_STAT_EN
   // sticky underflow flag and saturating underflow slot counter
   always_ff @(posedge Sys_clk) begin
      if (Rst) begin
         UNDERFLOW_FLAG <= 1'b0;
         UNDERFLOW_CNT  <= '0;
      end else if (w_underflow) begin
         UNDERFLOW_FLAG <= 1'b1;
         if (UNDERFLOW_CNT != '1) UNDERFLOW_CNT <= UNDERFLOW_CNT + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_pixel_out.sv
// tb_vga_pixel_out: scoreboard bench for vga_pixel_out on a shrunken raster.
// Define VGA_UNDERFLOW_STAT_EN to also check the underflow status ports.
module tb_vga_pixel_out;

   localparam int HA  = 10;
   localparam int HFP = 3;
   localparam int HSW = 5;
   localparam int HBP = 4;
   localparam int VA  = 4;
   localparam int VFP = 2;
   localparam int VSW = 2;
   localparam int VBP = 3;
   localparam int HT  = HA + HFP + HSW + HBP;
   localparam int VT  = VA + VFP + VSW + VBP;

   typedef struct packed {
      logic        de;
      logic        hs;
      logic        vs;
      logic        fs;
      logic [15:0] rgb;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       empty;
   logic [7:0] rd_data;
   logic       rd_en;
   logic       hs, vs, de, fs;
   logic [4:0] r;
   logic [5:0] g;
   logic [4:0] b;
`ifdef VGA_UNDERFLOW_STAT_EN
   logic        uf_flag;
   logic [15:0] uf_cnt;
`endif

   vga_pixel_out #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .SYNC_POL(1'b0)
   ) dut (
      .Sys_clk(clk),
      .Rst(rst),
      .VGA_START(start),
      .VGA_FIFO_EMPTY(empty),
      .VGA_FIFO_RD_EN(rd_en),
      .VGA_FIFO_RD_DATA(rd_data),
      .VGA_HS(hs),
      .VGA_VS(vs),
      .VGA_DE(de),
      .VGA_R(r),
      .VGA_G(g),
      .VGA_B(b),
      .FRAME_START(fs)
`ifdef VGA_UNDERFLOW_STAT_EN
      ,
      .UNDERFLOW_FLAG(uf_flag),
      .UNDERFLOW_CNT(uf_cnt)
`endif
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   exp_t sb[$];
   bit   m_run;
   int   m_h, m_v;
   logic [7:0] nb;
   int   byte_idx;
   int   rd_cnt;
   int   fs_last;
   bit   uf_win;
   int   m_uf_cnt;
   bit   m_uf_flag;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
      end
   endtask

   function automatic exp_t idle_exp();
      exp_t e;
      e    = '0;
      e.hs = 1'b1;
      e.vs = 1'b1;
      return e;
   endfunction

   function automatic logic [15:0] expand(input logic [7:0] d);
      logic [4:0] er;
      logic [5:0] eg;
      logic [4:0] eb;
      er = {d[7:5], d[7:6]};
      eg = {d[4:2], d[4:2]};
      eb = {d[1:0], d[1:0], d[1]};
      return {er, eg, eb};
   endfunction

   // One clock: compare at negedge, push expectation for this slot, advance model.
   task automatic tick();
      exp_t e;
      bit   act, exp_rd;
      @(negedge clk);
      if (sb.size() == 0) begin
         chk("sb_underrun", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk("de",  de, e.de);
         chk("hs",  hs, e.hs);
         chk("vs",  vs, e.vs);
         chk("fs",  fs, e.fs);
         chk("rgb", {r, g, b}, e.rgb);
      end
      if (fs) begin
         if (fs_last >= 0) chk("fs_period", cyc - fs_last, HT * VT);
         fs_last = cyc;
      end
      act    = m_run && (m_h < HA) && (m_v < VA);
      exp_rd = act && !empty;
      chk("rd_en", rd_en, exp_rd);
      if (rd_en) rd_cnt++;
`ifdef VGA_UNDERFLOW_STAT_EN
      chk("uf_flag", uf_flag, m_uf_flag);
      chk("uf_cnt",  uf_cnt,  m_uf_cnt);
`endif
      if (rst) begin
         sb.delete();
         sb.push_back(idle_exp());
         sb.push_back(idle_exp());
         fs_last = -1;
      end else begin
         e     = '0;
         e.de  = act;
         e.hs  = !(m_run && m_h >= HA + HFP && m_h < HA + HFP + HSW);
         e.vs  = !(m_run && m_v >= VA + VFP && m_v < VA + VFP + VSW);
         e.fs  = m_run && m_h == 0 && m_v == 0;
         e.rgb = exp_rd ? expand(nb) : 16'h0;
         sb.push_back(e);
      end
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_uf_cnt  = 0;
         m_uf_flag = 1'b0;
      end else if (act && empty) begin
         m_uf_flag = 1'b1;
         if (m_uf_cnt < 65535) m_uf_cnt++;
      end
      if (rst) begin
         m_run = 1'b0; m_h = 0; m_v = 0;
      end else if (!m_run) begin
         m_run = start;
      end else if (m_h == HT - 1) begin
         m_h = 0;
         m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
         m_h++;
      end
      #1;
      if (exp_rd) begin
         rd_data = nb;
         byte_idx++;
         nb = (byte_idx == 1) ? 8'h1F : 8'($urandom_range(0, 255));
      end
      empty = uf_win && m_run && m_v == 1 && m_h >= 3 && m_h <= 5;
   endtask

   initial begin
      int  k;
      bit  found;
      rst = 1'b1; start = 1'b0; empty = 1'b0; rd_data = '0;
      nb = 8'hE0; byte_idx = 0; rd_cnt = 0; fs_last = -1; uf_win = 1'b0;
      m_run = 1'b0; m_h = 0; m_v = 0; m_uf_cnt = 0; m_uf_flag = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      sb.push_back(idle_exp());
      sb.push_back(idle_exp());
      tick();

      // idle with start low: no reads, outputs inactive
      rst = 1'b0;
      rd_cnt = 0;
      for (int i = 0; i < 200; i++) tick();
      chk("idle_rd_cnt", rd_cnt, 0);

      // start, then drop start; first pixels carry E0 and 1F
      start = 1'b1;
      uf_win = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         k++;
         if (de) begin
            found = 1'b1;
            break;
         end
      end
      chk("first_de_seen", found, 1'b1);
      chk("first_de_delay", k, 2);
      chk("px0_rgb", {r, g, b}, {5'h1F, 6'h00, 5'h00});
      chk("px0_fs", fs, 1'b1);
      tick();
      chk("px1_rgb", {r, g, b}, {5'h00, 6'h3F, 5'h1F});

      // one full frame period containing the 3-slot underflow window
      rd_cnt = 0;
      for (int i = 0; i < HT * VT; i++) tick();
      chk("rd_frame_uf", rd_cnt, HA * VA - 3);
`ifdef VGA_UNDERFLOW_STAT_EN
      chk("uf_cnt_end", uf_cnt, 3);
      chk("uf_flag_end", uf_flag, 1'b1);
`endif
      uf_win = 1'b0;

      // clean frame period
      rd_cnt = 0;
      for (int i = 0; i < HT * VT; i++) tick();
      chk("rd_frame", rd_cnt, HA * VA);

      // reset mid-frame, then restart
      found = 1'b0;
      for (int i = 0; i < HT * VT + 2; i++) begin
         if (m_v == 2 && m_h == 7) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      chk("rst_pos_found", found, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      start = 1'b1;
      chk("rst_de", de, 1'b0);
      chk("rst_hs", hs, 1'b1);
      chk("rst_vs", vs, 1'b1);
      chk("rst_rgb", {r, g, b}, 16'h0);
      chk("rst_rd_en", rd_en, 1'b0);
      tick();
      start = 1'b0;
      rd_cnt = 0;
      for (int i = 0; i < HT * VT + 20; i++) tick();
      chk("rd_after_rst", rd_cnt >= HA * VA, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
